// File: rtl/spram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM request controller.
//   DATA_BYTES   : bytes per SRAM word (one byte-enable bit each)
//   DATA_WIDTH   : bits per SRAM word
//   ctrl_state_e : controller FSM state (zero-fill sweep, then normal service)
package spram_ctrl_pkg;

  localparam int unsigned DATA_BYTES = 8;
  localparam int unsigned DATA_WIDTH = 8 * DATA_BYTES;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } ctrl_state_e;

endpackage

// File: rtl/spram_rsp_fifo.sv
// Read-response FIFO with a fall-through head: when empty, a pushed word is visible on
// Head_DO in the same cycle and can be popped straight through without being stored.
// Ports:
//   Clk_CI, Rst_RBI : clock, async active-low reset (clears pointers and occupancy)
//   Push_SI/Push_DI : write strobe and data (never asserted while full)
//   Pop_SI          : consume the head word (only while Valid_SO)
//   Valid_SO        : head word present (stored or falling through)
//   Head_DO         : head word
//   Count_DO        : number of stored words
module spram_rsp_fifo
  import spram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RBI,
  input  logic                         Push_SI,
  input  logic [DATA_WIDTH-1:0]        Push_DI,
  input  logic                         Pop_SI,
  output logic                         Valid_SO,
  output logic [DATA_WIDTH-1:0]        Head_DO,
  output logic [$clog2(DEPTH+1)-1:0]   Count_DO
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  empty, bypass, wr_en, rd_en;

  assign empty  = (count_q == '0);
  // Push and pop on an empty FIFO hand the word straight through.
  assign bypass = empty & Push_SI & Pop_SI;
  assign wr_en  = Push_SI & ~bypass;
  assign rd_en  = Pop_SI & ~empty;

  assign Valid_SO = ~empty | Push_SI;
  assign Head_DO  = empty ? Push_DI : mem_q[rd_ptr_q];
  assign Count_DO = count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Storage needs no reset: only words covered by count_q are ever read.
  always_ff @(posedge Clk_CI) begin
    if (wr_en) mem_q[wr_ptr_q] <= Push_DI;
  end

endmodule

// File: rtl/spram_req_ctrl.sv
// Request controller for a single-port SRAM with 1+OUT_REGS read latency.
// After reset it optionally zero-fills the SRAM, then accepts read/write requests,
// drives the SRAM port combinationally from accepted requests and returns read data
// in order through a credit-protected response FIFO.
// Ports:
//   Clk_CI, Rst_RBI         : clock, async active-low reset
//   Req_*                   : valid/ready request (We, byte enables, word address, data)
//   Rsp_*                   : valid/ready read response
//   Init_Done_SO            : init sweep finished, requests accepted
//   Ram_*_SO/DO, Ram_RdData_DI : SRAM port
module spram_req_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Req_Valid_SI,
  output logic                  Req_Ready_SO,
  input  logic                  Req_We_SI,
  input  logic [DATA_BYTES-1:0] Req_BEn_SI,
  input  logic [ADDR_WIDTH-1:0] Req_Addr_DI,
  input  logic [DATA_WIDTH-1:0] Req_WrData_DI,
  output logic                  Rsp_Valid_SO,
  input  logic                  Rsp_Ready_SI,
  output logic [DATA_WIDTH-1:0] Rsp_RdData_DO,
  output logic                  Init_Done_SO,
  output logic                  Ram_CSel_SO,
  output logic                  Ram_WrEn_SO,
  output logic [DATA_BYTES-1:0] Ram_BEn_SO,
  output logic [ADDR_WIDTH-1:0] Ram_Addr_DO,
  output logic [DATA_WIDTH-1:0] Ram_WrData_DO,
  input  logic [DATA_WIDTH-1:0] Ram_RdData_DI
);

  localparam int unsigned LAT        = 1 + OUT_REGS;
  localparam int unsigned FIFO_DEPTH = LAT + 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] INIT_LAST  = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  ctrl_state_e           state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;
  logic [LAT-1:0]        tag_vld_q, tag_oor_q;

  logic                  init_wr, in_range, req_ready, accept, rd_acc;
  logic                  fifo_push, fifo_pop, fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_push_data;
  logic [CNT_W-1:0]      fifo_count, in_flight, used_slots;

  // Controller FSM: zero-fill sweep (or a single idle cycle), then service.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (INIT_ZERO == 0 || init_cnt_q == INIT_LAST) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
          end
        end
        StRun: state_q <= StRun;
        default: state_q <= StInit;
      endcase
    end
  end

  assign Init_Done_SO = init_done_q;

  // Qualified with the reset pin so the SRAM is not selected while reset is held.
  assign init_wr  = (state_q == StInit) && (INIT_ZERO != 0) && Rst_RBI;
  assign in_range = ({1'b0, Req_Addr_DI} < ADDR_LIMIT);

  // Credit: every accepted read owns a slot until its response is popped.
  assign in_flight  = CNT_W'($countones(tag_vld_q));
  assign fifo_pop   = fifo_valid & Rsp_Ready_SI;
  assign used_slots = fifo_count + in_flight - CNT_W'(fifo_pop);
  assign req_ready  = init_done_q && (used_slots < CNT_W'(FIFO_DEPTH));
  assign accept     = Req_Valid_SI & req_ready;
  assign rd_acc     = accept & ~Req_We_SI;

  assign Req_Ready_SO = req_ready;

  always_comb begin
    Ram_CSel_SO   = 1'b0;
    Ram_WrEn_SO   = 1'b0;
    Ram_BEn_SO    = '0;
    Ram_Addr_DO   = '0;
    Ram_WrData_DO = '0;
    if (init_wr) begin
      Ram_CSel_SO   = 1'b1;
      Ram_WrEn_SO   = 1'b1;
      Ram_BEn_SO    = '1;
      Ram_Addr_DO   = init_cnt_q;
    end else if (accept && in_range) begin
      Ram_CSel_SO   = 1'b1;
      Ram_WrEn_SO   = Req_We_SI;
      Ram_BEn_SO    = Req_BEn_SI;
      Ram_Addr_DO   = Req_Addr_DI;
      Ram_WrData_DO = Req_WrData_DI;
    end
  end

  // Tag pipeline tracks each read across the SRAM latency; out-of-range reads
  // never select the SRAM and return zero.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      tag_vld_q <= '0;
      tag_oor_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_acc;
      tag_oor_q[0] <= rd_acc & ~in_range;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_oor_q[i] <= tag_oor_q[i-1];
      end
    end
  end

  assign fifo_push      = tag_vld_q[LAT-1];
  assign fifo_push_data = tag_oor_q[LAT-1] ? '0 : Ram_RdData_DI;

  spram_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .Clk_CI   (Clk_CI),
    .Rst_RBI  (Rst_RBI),
    .Push_SI  (fifo_push),
    .Push_DI  (fifo_push_data),
    .Pop_SI   (fifo_pop),
    .Valid_SO (fifo_valid),
    .Head_DO  (Rsp_RdData_DO),
    .Count_DO (fifo_count)
  );

  assign Rsp_Valid_SO = fifo_valid;

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Bench for spram_req_ctrl: two instances (A: 16 words, 2-cycle SRAM, 5-bit address;
// B: 1000 words, 1-cycle SRAM, 10-bit address), each with a behavioural SRAM, checked
// against a transaction-level model (word array + queue of expected responses).
module tb_spram_req_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n, sel;
  logic        req_valid, req_we, rsp_ready;
  logic [7:0]  req_ben;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;

  logic        a_req_ready, a_rsp_valid, a_init_done, a_csel, a_wen;
  logic [7:0]  a_ben;
  logic [4:0]  a_addr;
  logic [63:0] a_wdata, a_rsp_data, a_rdata;
  logic        b_req_ready, b_rsp_valid, b_init_done, b_csel, b_wen;
  logic [7:0]  b_ben;
  logic [9:0]  b_addr;
  logic [63:0] b_wdata, b_rsp_data, b_rdata;

  spram_req_ctrl #(
    .ADDR_WIDTH (5), .DATA_DEPTH (16), .OUT_REGS (1), .INIT_ZERO (1)
  ) dut_a (
    .Clk_CI (clk), .Rst_RBI (rst_a_n),
    .Req_Valid_SI (req_valid & ~sel), .Req_Ready_SO (a_req_ready), .Req_We_SI (req_we),
    .Req_BEn_SI (req_ben), .Req_Addr_DI (req_addr[4:0]), .Req_WrData_DI (req_wdata),
    .Rsp_Valid_SO (a_rsp_valid), .Rsp_Ready_SI (rsp_ready & ~sel), .Rsp_RdData_DO (a_rsp_data),
    .Init_Done_SO (a_init_done), .Ram_CSel_SO (a_csel), .Ram_WrEn_SO (a_wen),
    .Ram_BEn_SO (a_ben), .Ram_Addr_DO (a_addr), .Ram_WrData_DO (a_wdata),
    .Ram_RdData_DI (a_rdata)
  );

  spram_req_ctrl #(
    .ADDR_WIDTH (10), .DATA_DEPTH (1000), .OUT_REGS (0), .INIT_ZERO (1)
  ) dut_b (
    .Clk_CI (clk), .Rst_RBI (rst_b_n),
    .Req_Valid_SI (req_valid & sel), .Req_Ready_SO (b_req_ready), .Req_We_SI (req_we),
    .Req_BEn_SI (req_ben), .Req_Addr_DI (req_addr), .Req_WrData_DI (req_wdata),
    .Rsp_Valid_SO (b_rsp_valid), .Rsp_Ready_SI (rsp_ready & sel), .Rsp_RdData_DO (b_rsp_data),
    .Init_Done_SO (b_init_done), .Ram_CSel_SO (b_csel), .Ram_WrEn_SO (b_wen),
    .Ram_BEn_SO (b_ben), .Ram_Addr_DO (b_addr), .Ram_WrData_DO (b_wdata),
    .Ram_RdData_DI (b_rdata)
  );

  // Observed outputs of the instance under test.
  logic        o_req_ready, o_rsp_valid, o_init_done, o_csel, o_wen;
  logic [7:0]  o_ben;
  logic [9:0]  o_addr;
  logic [63:0] o_wdata, o_rsp_data;
  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
  assign o_init_done = sel ? b_init_done : a_init_done;
  assign o_csel      = sel ? b_csel      : a_csel;
  assign o_wen       = sel ? b_wen       : a_wen;
  assign o_ben       = sel ? b_ben       : a_ben;
  assign o_addr      = sel ? b_addr      : {5'b0, a_addr};
  assign o_wdata     = sel ? b_wdata     : a_wdata;

  // Behavioural SRAMs: contents start as garbage, read data is garbage outside the
  // exact latency slot.
  logic        seeded = 1'b0;
  logic [63:0] mem_a [32];
  logic [63:0] mem_b [1024];
  logic [63:0] a_rd0, a_rd1, b_rd0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= {$urandom, $urandom};
      for (int i = 0; i < 1024; i++) mem_b[i] <= {$urandom, $urandom};
      seeded <= 1'b1;
    end else begin
      if (a_csel && a_wen)
        for (int j = 0; j < 8; j++) if (a_ben[j]) mem_a[a_addr][8*j +: 8] <= a_wdata[8*j +: 8];
      if (b_csel && b_wen)
        for (int j = 0; j < 8; j++) if (b_ben[j]) mem_b[b_addr][8*j +: 8] <= b_wdata[8*j +: 8];
    end
    a_rd0 <= (a_csel && !a_wen) ? mem_a[a_addr] : {$urandom, $urandom};
    a_rd1 <= a_rd0;
    b_rd0 <= (b_csel && !b_wen) ? mem_b[b_addr] : {$urandom, $urandom};
  end
  assign a_rdata = a_rd1;
  assign b_rdata = b_rd0;

  // Reference model.
  typedef struct {
    logic [63:0] data;
    int          due;
  } rsp_t;
  rsp_t        exp_q[$];
  logic [63:0] ref_mem [1024];
  logic [63:0] last_rsp;
  int          cyc, checks, errors, depth_m, lat_m;
  bit          run_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    #1;
    chk("reset_outputs", {o_req_ready, o_rsp_valid, o_init_done, o_csel, o_wen, o_ben, o_addr,
        o_wdata}, '0);
  endtask

  // Called right after reset is released at a falling edge.
  task automatic sweep(input int depth, input int lat);
    for (int k = 0; k < depth; k++) begin
      #1;
      chk("init_write", {o_csel, o_wen, o_ben, o_addr, o_wdata, o_init_done, o_req_ready},
          {1'b1, 1'b1, 8'hFF, 10'(k), 64'h0, 1'b0, 1'b0});
      @(negedge clk);
    end
    #1;
    chk("init_done", o_init_done, 1'b1);
    for (int i = 0; i < depth; i++) ref_mem[i] = 64'h0;
    exp_q.delete();
    run_m   = 1'b1;
    depth_m = depth;
    lat_m   = lat;
  endtask

  task automatic step(input bit v, input bit we, input logic [7:0] ben, input logic [9:0] addr,
                      input logic [63:0] wd, input bit rr, output bit acc);
    bit avail, pop, exp_rdy, inr;
    int used;
    @(negedge clk);
    req_valid = v; req_we = we; req_ben = ben; req_addr = addr; req_wdata = wd; rsp_ready = rr;
    #1;
    avail = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    chk("rsp_valid", o_rsp_valid, avail);
    if (avail) chk("rsp_data", o_rsp_data, exp_q[0].data);
    pop     = avail && rr;
    used    = exp_q.size() - (pop ? 1 : 0);
    exp_rdy = run_m && (used < lat_m + 1);
    chk("req_ready", o_req_ready, exp_rdy);
    acc = v && exp_rdy;
    inr = (int'(addr) < depth_m);
    if (acc && !inr) chk("ram_csel_oor", o_csel, 1'b0);
    else if (acc) chk("ram_drive", {o_csel, o_wen, o_ben, o_addr, o_wdata}, {1'b1, we, ben, addr, wd});
    else chk("ram_idle", {o_csel, o_wen, o_ben, o_addr, o_wdata}, '0);
    if (pop) begin
      last_rsp = o_rsp_data;
      void'(exp_q.pop_front());
    end
    if (acc && we && inr)
      for (int j = 0; j < 8; j++) if (ben[j]) ref_mem[addr][8*j +: 8] = wd[8*j +: 8];
    if (acc && !we) exp_q.push_back('{inr ? ref_mem[addr] : 64'h0, cyc + lat_m});
    cyc++;
  endtask

  task automatic drain(input int budget);
    bit acc;
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step(1'b0, 1'b0, 8'h0, 10'h0, 64'h0, 1'b1, acc);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 128'(exp_q.size()), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

  initial begin
    bit acc;
    int idx, budget;
    checks = 0; errors = 0; cyc = 0; run_m = 1'b0; depth_m = 16; lat_m = 2;
    sel = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_ben = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks();
    sel = 1'b1;
    reset_checks();
    sel = 1'b0;

    // Instance A: zero-fill sweep, then read back zero.
    @(negedge clk);
    rst_a_n = 1'b1;
    sweep(16, 2);
    step(1'b1, 1'b0, 8'hFF, 10'd5, 64'h0, 1'b1, acc);
    drain(10);
    chk("read_after_init", last_rsp, 64'h0);

    // Byte-enable merge.
    step(1'b1, 1'b1, 8'hFF, 10'd3, 64'h1122334455667788, 1'b1, acc);
    step(1'b1, 1'b1, 8'h0F, 10'd3, 64'hAAAAAAAAAAAAAAAA, 1'b1, acc);
    step(1'b1, 1'b0, 8'hFF, 10'd3, 64'h0, 1'b1, acc);
    drain(10);
    chk("ben_merge", last_rsp, 64'h11223344AAAAAAAA);

    // Back-pressure: distinct data at 0..4, then 5 reads with the consumer stalled.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 8'hFF, 10'(i), {32'hC0DE0000 + 32'(i), 32'(i) * 32'h01010101}, 1'b1, acc);
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, 8'hFF, 10'(idx), 64'h0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("stall_accepts", 128'(idx), 128'd3);
    chk("stall_ready", o_req_ready, 1'b0);
    budget = 20;
    while (idx < 5 && budget > 0) begin
      step(1'b1, 1'b0, 8'hFF, 10'(idx), 64'h0, 1'b1, acc);
      if (acc) idx++;
      budget--;
    end
    if (idx < 5) chk("stall_release_timeout", 128'(idx), 128'd5);
    drain(20);

    // Sustained one read per cycle with the consumer always ready.
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, 8'hFF, 10'(c), 64'h0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("throughput", 128'(idx), 128'd8);
    drain(10);

    // Random traffic on A, addresses partly out of range.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 9) < 7, 1'($urandom), 8'($urandom), 10'($urandom_range(0, 19)),
           {$urandom, $urandom}, $urandom_range(0, 9) < 6, acc);
    drain(20);

    // Reset with two reads in flight.
    step(1'b1, 1'b0, 8'hFF, 10'd1, 64'h0, 1'b0, acc);
    step(1'b1, 1'b0, 8'hFF, 10'd2, 64'h0, 1'b0, acc);
    @(negedge clk);
    req_valid = 1'b0;
    rst_a_n = 1'b0;
    run_m = 1'b0;
    exp_q.delete();
    reset_checks();
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    sweep(16, 2);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 8'h0, 10'h0, 64'h0, 1'b1, acc);

    // Instance B: 1000 words, 1-cycle SRAM.
    step(1'b0, 1'b0, 8'h0, 10'h0, 64'h0, 1'b0, acc);
    @(negedge clk);
    sel = 1'b1;
    run_m = 1'b0;
    rst_b_n = 1'b1;
    sweep(1000, 1);
    step(1'b1, 1'b1, 8'hFF, 10'd1010, 64'hDEADBEEFDEADBEEF, 1'b1, acc);
    step(1'b1, 1'b0, 8'hFF, 10'd1010, 64'h0, 1'b1, acc);
    drain(10);
    chk("oor_read_zero", last_rsp, 64'h0);
    for (int n = 0; n < 200; n++)
      step($urandom_range(0, 9) < 7, 1'($urandom), 8'($urandom),
           ($urandom_range(0, 1) != 0) ? 10'($urandom_range(980, 1023)) : 10'($urandom_range(0, 7)),
           {$urandom, $urandom}, $urandom_range(0, 9) < 5, acc);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
